uart_rx_core: RTL
=================

# uart_rx_core

UART receiver for the motor-control serial link, directly downstream of the `clk_div` baud divider. It consumes the divider's 16x-baud square wave on `BAUD_X16` and samples the asynchronous `RX` line. It delivers each received byte with a one-cycle valid strobe to the command decoder. Frame format is 8N1, with optional even parity.

## Interface
Parameters:
- `DATA_BITS`, default 8: data bits per frame, LSB first.
- `OVS`, default 16: oversampling ticks per bit; must be a power of two, at least 8.

Ports:
- `CLK`  in  1  system clock; all logic on rising edge.
- `RST_N`  in  1  reset; asynchronous, active-low.
- `BAUD_X16`  in  1  `clk_div` output, a square wave at OVS x baud. Asynchronous to nothing: it is derived from `CLK`.
- `RX`  in  1  serial input; asynchronous; idle high.
- `RX_DATA`  out  DATA_BITS  last good byte.
- `RX_VALID`  out  1  one-cycle pulse when `RX_DATA` is updated.
- `FRAME_ERR`  out  1  one-cycle pulse when the stop bit is sampled low.
- `PARITY_ERR`  out  1  one-cycle pulse, coincident with `RX_VALID`, when the parity check fails.
- `BUSY`  out  1  high in any state other than IDLE.

## Operation
- **Tick generation.** `BAUD_X16` is registered once. A rising edge (previous value 0, current value 1) produces the one-cycle internal enable `tick`. All bit timing advances only on `tick`.
- **RX synchronizer.** `RX` passes through a 2-flop synchronizer to give `rx_s`; reset value is 1.
- **Counters.**
  - Tick counter `cnt`: log2(OVS) bits, wraps naturally.
  - Bit counter `bitn`: log2(DATA_BITS)+1 bits.
- **FSM states:** IDLE, START, DATA, PARITY, STOP, WAIT_HI.
  - **IDLE:** on a `tick` with `rx_s`=0, set `cnt`<=0 and go to START.
  - **START:** on the `tick` with `cnt`==OVS/2-1 (mid start bit), sample `rx_s`.
    - Sample is 1 (glitch): go to IDLE.
    - Sample is 0: set `cnt`<=0, `bitn`<=0, go to DATA.
  - **DATA:** on each `tick` with `cnt`==OVS-1, shift `rx_s` into the MSB of the shift register (right shift, so data arrives LSB first) and increment `bitn`.
    - After DATA_BITS samples: go to PARITY if `UART_PARITY_EN` is defined, otherwise go to STOP.
  - **PARITY:** on the `tick` with `cnt`==OVS-1, latch the parity bit and go to STOP.
  - **STOP:** on the `tick` with `cnt`==OVS-1, sample `rx_s`.
    - Sample is 1: load `RX_DATA` from the shift register, pulse `RX_VALID`, go to IDLE.
    - Sample is 0: pulse `FRAME_ERR`, leave `RX_DATA` unchanged, go to WAIT_HI.
  - **WAIT_HI:** go to IDLE on the first `tick` with `rx_s`=1. This prevents a break condition from retriggering reception.
- **Output pulses.** `RX_VALID`, `FRAME_ERR` and `PARITY_ERR` are registered, high for exactly one `CLK` cycle, and never high at the same time as each other, except that `PARITY_ERR` coincides with `RX_VALID`.

## Timing
- **Reset values.**
  - `RX_DATA`=0; `RX_VALID`=`FRAME_ERR`=`PARITY_ERR`=`BUSY`=0.
  - FSM=IDLE; `rx_s`=1; `cnt`=`bitn`=0.
- **Reset mid-frame.** An asserted `RST_N` aborts the frame immediately, with no output pulse. After release the block waits in IDLE for a new falling edge.
- **Tick timeline.** Let the start-detect `tick` be T0.
  - Start bit sampled at T0+OVS/2 ticks.
  - Data bit k sampled at T0+OVS/2+OVS(k+1) ticks.
  - Stop bit sampled at T0+OVS/2+OVS(DATA_BITS+1) ticks, i.e. T0+152 for OVS=16, 8N1. Add OVS ticks when parity is enabled.
- **Output latency.** `RX_VALID` or `FRAME_ERR` goes high on the `CLK` cycle after the stop-sample `tick`.
- **Input delay.** `RX` to `rx_s` is 2 `CLK` cycles. `BAUD_X16` edge to `tick` is 1 `CLK` cycle.
- **Back-to-back frames.** A start bit that immediately follows a good stop bit is detected within one tick period. Back-to-back frames need no idle gap.
- **Tick rate.** `tick` is never faster than one every 2 `CLK` cycles, so a `BAUD_X16` held constant produces no ticks and the FSM freezes.

## Configuration
- Macro: `UART_PARITY_EN`.
- **Defined:** the PARITY state is compiled in. The expected parity bit is the XOR of the data bits (even parity). On a mismatch, `PARITY_ERR` pulses together with `RX_VALID`, and `RX_DATA` is still updated.
- **Undefined:** the PARITY state and parity logic are removed. `PARITY_ERR` is tied to 0. The frame is exactly 1+DATA_BITS+1 bits.

## Test plan
- **Good byte.** 100 MHz `CLK`, `BAUD_X16` at 16x 115200; send 0xA5 as 8N1 -> `RX_DATA`=0xA5, a single one-cycle `RX_VALID`, `BUSY` low afterwards.
- **Start-bit glitch.** `RX` low for 4 ticks, then high -> FSM returns to IDLE; no `RX_VALID` and no `FRAME_ERR`.
- **Framing error.** Send 0x3C with the stop bit low, hold `RX` low for 40 ticks, then send 0x81 -> one `FRAME_ERR`, `RX_DATA` stays at its prior value; then `RX_VALID` with 0x81. No spurious frame is received during the low period.
- **Back-to-back.** Send 0x00 and 0xFF with no gap -> two `RX_VALID` pulses, carrying 0x00 then 0xFF, 160 ticks apart.
- **Reset mid-frame.** Assert `RST_N` low during bit 3 of 0x55, release, then send 0x12 -> no pulse for the aborted frame; next `RX_VALID` carries 0x12.
- **Parity error.** With `UART_PARITY_EN` defined, send 0x03 with parity bit 1 -> `RX_VALID` together with `PARITY_ERR`, `RX_DATA`=0x03. With parity bit 0 -> `PARITY_ERR` stays 0.

Source files
------------

// File: rtl/uart_rx_core.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_rx_core
// Brief    : 8N1 UART receiver (optional even parity) clocked on CLK and
//            paced by the OVS x baud square wave from clk_div.
//            Configuration macro: UART_PARITY_EN (defined = even parity
//            bit expected between the last data bit and the stop bit).
// Ports    : CLK        system clock, rising edge
//            RST_N      asynchronous active-low reset
//            BAUD_X16   OVS x baud square wave (derived from CLK)
//            RX         asynchronous serial input, idle high
//            RX_DATA    last good byte
//            RX_VALID   one-cycle pulse when RX_DATA is updated
//            FRAME_ERR  one-cycle pulse when the stop bit is sampled low
//            PARITY_ERR one-cycle pulse with RX_VALID on a parity mismatch
//            BUSY       high whenever the receiver is not idle
// Revision : 1.0  initial release
// ============================================================================
module uart_rx_core #(
    parameter int DATA_BITS = 8,
    parameter int OVS       = 16
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 BAUD_X16,
    input  logic                 RX,
    output logic [DATA_BITS-1:0] RX_DATA,
    output logic                 RX_VALID,
    output logic                 FRAME_ERR,
    output logic                 PARITY_ERR,
    output logic                 BUSY
);

    localparam int c_CNT_W = $clog2(OVS);
    localparam int c_BIT_W = $clog2(DATA_BITS) + 1;

    localparam logic [c_CNT_W-1:0] c_CNT_MID  = c_CNT_W'(OVS / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_END  = c_CNT_W'(OVS - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_DATA    = 3'd2,
        S_PARITY  = 3'd3,
        S_STOP    = 3'd4,
        S_WAIT_HI = 3'd5
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t                 r_state;
    logic                   r_baud;
    logic                   r_tick;
    logic                   r_rx_meta;
    logic                   r_rx_s;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [c_BIT_W-1:0]     r_bitn;
    logic [DATA_BITS-1:0]   r_shift;
    logic [DATA_BITS-1:0]   r_rx_data;
    logic                   r_rx_valid;
    logic                   r_frame_err;

    // ------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------
    state_t                 w_state_nxt;
    logic [c_CNT_W-1:0]     w_cnt_nxt;
    logic [c_BIT_W-1:0]     w_bitn_nxt;
    logic [DATA_BITS-1:0]   w_shift_nxt;
    logic [DATA_BITS-1:0]   w_rx_data_nxt;
    logic                   w_rx_valid_nxt;
    logic                   w_frame_err_nxt;

`ifdef UART_PARITY_EN
    logic                   r_par_bit;
    logic                   r_parity_err;
    logic                   w_par_bit_nxt;
    logic                   w_parity_err_nxt;
`endif

    // Tick is the registered rising edge of BAUD_X16; the RX synchronizer
    // and the tick pipeline live outside the FSM process.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_baud    <= 1'b0;
            r_tick    <= 1'b0;
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_baud    <= BAUD_X16;
            r_tick    <= BAUD_X16 & ~r_baud;
            r_rx_meta <= RX;
            r_rx_s    <= r_rx_meta;
        end
    end

    // ------------------------------------------------------------------
    // FSM state and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_bitn      <= '0;
            r_shift     <= '0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_bitn      <= w_bitn_nxt;
            r_shift     <= w_shift_nxt;
            r_rx_data   <= w_rx_data_nxt;
            r_rx_valid  <= w_rx_valid_nxt;
            r_frame_err <= w_frame_err_nxt;
        end
    end

`ifdef UART_PARITY_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_par_bit    <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_par_bit    <= w_par_bit_nxt;
            r_parity_err <= w_parity_err_nxt;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        // The tick counter free-runs and wraps, so one full bit period
        // after any resync point it is back at the same phase.
        w_cnt_nxt       = r_tick ? r_cnt + 1'b1 : r_cnt;
        w_bitn_nxt      = r_bitn;
        w_shift_nxt     = r_shift;
        w_rx_data_nxt   = r_rx_data;
        w_rx_valid_nxt  = 1'b0;
        w_frame_err_nxt = 1'b0;
`ifdef UART_PARITY_EN
        w_par_bit_nxt    = r_par_bit;
        w_parity_err_nxt = 1'b0;
`endif

        case (r_state)
            S_IDLE: begin
                if (r_tick && !r_rx_s) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_START;
                end
            end

            S_START: begin
                if (r_tick && (r_cnt == c_CNT_MID)) begin
                    if (r_rx_s) begin
                        // Start bit did not survive to mid-bit: glitch.
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_cnt_nxt   = '0;
                        w_bitn_nxt  = '0;
                        w_state_nxt = S_DATA;
                    end
                end
            end

            S_DATA: begin
                if (r_tick && (r_cnt == c_CNT_END)) begin
                    // Right shift: first bit received ends up in the LSB.
                    w_shift_nxt = DATA_BITS'({r_rx_s, r_shift} >> 1);
                    w_bitn_nxt  = r_bitn + 1'b1;
                    if (r_bitn == c_BIT_LAST) begin
`ifdef UART_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end
                end
            end

`ifdef UART_PARITY_EN
            S_PARITY: begin
                if (r_tick && (r_cnt == c_CNT_END)) begin
                    w_par_bit_nxt = r_rx_s;
                    w_state_nxt   = S_STOP;
                end
            end
`endif

            S_STOP: begin
                if (r_tick && (r_cnt == c_CNT_END)) begin
                    if (r_rx_s) begin
                        w_rx_data_nxt  = r_shift;
                        w_rx_valid_nxt = 1'b1;
`ifdef UART_PARITY_EN
                        // Even parity: the parity bit equals the XOR of the data.
                        w_parity_err_nxt = r_par_bit ^ (^r_shift);
`endif
                        w_state_nxt    = S_IDLE;
                    end else begin
                        w_frame_err_nxt = 1'b1;
                        w_state_nxt     = S_WAIT_HI;
                    end
                end
            end

            S_WAIT_HI: begin
                // Hold off until the line returns high so a break is not
                // taken as a stream of start bits.
                if (r_tick && r_rx_s) begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign RX_DATA   = r_rx_data;
    assign RX_VALID  = r_rx_valid;
    assign FRAME_ERR = r_frame_err;
    assign BUSY      = (r_state != S_IDLE);

`ifdef UART_PARITY_EN
    assign PARITY_ERR = r_parity_err;
`else
    assign PARITY_ERR = 1'b0;
`endif

endmodule
`default_nettype wire
